// File: rtl/rep_pkg.sv
// rtl/rep_pkg.sv - shared types and sizes for the repacking stage
// Ports: none (package).
package rep_pkg;

  localparam int IN_BYTES  = 3;
  localparam int OUT_BYTES = 4;

  // Enum value equals the number of residual bytes held in the accumulator.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B3 = 2'd3,
    B2 = 2'd2,
    B1 = 2'd1
  } pack_state_e;

  typedef struct packed {
    logic [8*OUT_BYTES-1:0] data;
    logic                   sop;
    logic                   eop;
    logic [1:0]             empty;
  } entry_t;

endpackage

// File: rtl/rep_fifo.sv
// rtl/rep_fifo.sv - show-ahead FIFO of packed output entries
// Ports:
//   clk_i, nrst_i      clock, asynchronous active-low reset
//   push_i, wr_data_i  write request and entry; ignored when full unless popping
//   pop_i              read request; ignored when empty
//   rd_data_o          head entry (valid while empty_o is low)
//   full_o, empty_o    occupancy flags
module rep_fifo
  import rep_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk_i,
  input  logic   nrst_i,
  input  logic   push_i,
  input  entry_t wr_data_i,
  input  logic   pop_i,
  output entry_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en, rd_en;
  entry_t      mem_q [DEPTH];

  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rd_en     = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en     = push_i && (!full_o || rd_en);
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_en};
    rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/rep_packer.sv
// rtl/rep_packer.sv - packs a 3-byte valid-only stream into 4-byte sop/eop words
// Ports:
//   clk_i, nrst_i            clock, asynchronous active-low reset
//   snk_data_i, snk_vd_i     input bytes (oldest in [7:0]), accepted whenever valid
//   src_data_o, src_vd_o     output word (oldest byte in [7:0]) and FIFO-not-empty
//   src_rdy_i                consumer ready; pop on src_vd_o && src_rdy_i
//   src_sop_o, src_eop_o     packet first / last word
//   src_empty_o              unused high bytes in an eop word
//   ovf_o, ovf_clr_i         sticky overflow flag and its clear
module rep_packer
  import rep_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int IDLE_FLUSH = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [23:0] snk_data_i,
  input  logic        snk_vd_i,
  output logic [31:0] src_data_o,
  output logic        src_vd_o,
  input  logic        src_rdy_i,
  output logic        src_sop_o,
  output logic        src_eop_o,
  output logic [1:0]  src_empty_o,
  output logic        ovf_o,
  input  logic        ovf_clr_i
);

  localparam int ACC_W = 8 * (IN_BYTES + OUT_BYTES - 1);
  localparam int IW    = $clog2(IDLE_FLUSH + 1);

  pack_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  entry_t           pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             open_q, open_d;
  logic             sop_q, sop_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       res;
  logic [ACC_W-1:0] merged;
  logic             flush;
  logic             push;
  logic             pop;
  logic             fifo_full, fifo_empty;
  entry_t           head;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idle_d     = idle_q;
    open_d     = open_q;
    sop_d      = sop_q;
    push       = 1'b0;

    res    = state_q;
    // Accumulator bytes above the residual are always zero, so OR appends.
    merged = acc_q | (ACC_W'(snk_data_i) << {res, 3'b000});
    flush  = !snk_vd_i && open_q && (idle_q == IW'(IDLE_FLUSH - 1));

    if (snk_vd_i) begin
      idle_d = '0;
      open_d = 1'b1;
      if (state_q == B0) begin
        acc_d   = merged;
        state_d = B3;
        if (pend_vld_q && pend_q.eop) begin
          push       = 1'b1;
          pend_vld_d = 1'b0;
        end
      end else begin
        // A full word forms; whatever was pending (eop or not) leaves now.
        push       = pend_vld_q;
        pend_d     = '{data: merged[31:0], sop: sop_q, eop: 1'b0, empty: 2'd0};
        pend_vld_d = 1'b1;
        sop_d      = 1'b0;
        acc_d      = merged >> 32;
        state_d    = pack_state_e'(res - 2'd1);
      end
    end else begin
      if (idle_q != IW'(IDLE_FLUSH)) begin
        idle_d = idle_q + 1'b1;
      end
      if (pend_vld_q && pend_q.eop) begin
        push       = 1'b1;
        pend_vld_d = 1'b0;
      end
      if (flush) begin
        open_d = 1'b0;
        // The next word formed belongs to a new packet regardless of
        // whether this eop entry later survives the FIFO.
        sop_d  = 1'b1;
        if (state_q != B0) begin
          push       = pend_vld_q;
          // empty = 4 - residual, taken modulo 4.
          pend_d     = '{data: acc_q[31:0], sop: sop_q, eop: 1'b1, empty: 2'd0 - res};
          pend_vld_d = 1'b1;
          acc_d      = '0;
          state_d    = B0;
        end else begin
          pend_d.eop   = 1'b1;
          pend_d.empty = 2'd0;
        end
      end
    end

    pop   = !fifo_empty && src_rdy_i;
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= B0;
      acc_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idle_q     <= '0;
      open_q     <= 1'b0;
      sop_q      <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idle_q     <= idle_d;
      open_q     <= open_d;
      sop_q      <= sop_d;
      ovf_q      <= ovf_d;
    end
  end

  rep_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .push_i   (push),
    .wr_data_i(pend_q),
    .pop_i    (pop),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Head is gated so the outputs read zero whenever nothing is valid.
  assign src_vd_o    = !fifo_empty;
  assign src_data_o  = src_vd_o ? head.data  : '0;
  assign src_sop_o   = src_vd_o && head.sop;
  assign src_eop_o   = src_vd_o && head.eop;
  assign src_empty_o = src_vd_o ? head.empty : 2'd0;
  assign ovf_o       = ovf_q;

endmodule
